// File: rtl/teclado_scan_n.sv
// teclado_scan_n: matrix keypad scanner with 2-flop row sync, press/release debounce,
// hex or linear keymap, single-cycle key pulse and a wrapping N_DIGITOS digit buffer.
module teclado_scan_n #(
   parameter int N_FILAS   = 4,
   parameter int N_COLS    = 4,
   parameter int T_COL     = 3,
   parameter int DEB_CNT   = 4,
   parameter int N_DIGITOS = 3,
   parameter int MAPA_HEX  = 1,
   parameter int CW        = (MAPA_HEX == 1) ? 4 : $clog2(N_FILAS * N_COLS),
   parameter int PW        = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_FILAS-1:0]      fila,
   input  logic                    borrar,
   output logic [N_COLS-1:0]       col,
   output logic [CW-1:0]           tecla,
   output logic                    tecla_valida,
   output logic [N_DIGITOS*CW-1:0] digitos,
   output logic [PW-1:0]           desp
);
   localparam int RW  = $clog2(N_FILAS);
   localparam int CIW = $clog2(N_COLS);
   localparam int DWW = $clog2(T_COL);
   localparam int KW  = $clog2(DEB_CNT + 1);
   localparam int DW  = N_DIGITOS * CW;
   // nibble k holds the hex code of key index row*4+col
   localparam logic [63:0] HEX = 64'hDE0FC987B654A321;

   typedef enum logic [1:0] {SCAN, DEB_P, PRES, DEB_R} estado_t;

   estado_t          r_est, w_est;
   logic [N_FILAS-1:0] r_fm, r_fs, r_fl, w_fl;
   logic [CIW-1:0]   r_ci, w_ci, w_ci_sig;
   logic [DWW-1:0]   r_dw, w_dw;
   logic [KW-1:0]    r_k, w_k;
   logic [CW-1:0]    r_tecla, w_code;
   logic             r_val, w_acc, w_uno, w_fin;
   logic [DW-1:0]    r_dig, w_dig;
   logic [PW-1:0]    r_desp, w_desp;
   logic [RW-1:0]    w_row;

   assign col          = N_COLS'(1) << r_ci;
   assign tecla        = r_tecla;
   assign tecla_valida = r_val;
   assign digitos      = r_dig;
   assign desp         = r_desp;

   assign w_uno    = (r_fs != '0) && ((r_fs & (r_fs - N_FILAS'(1))) == '0);
   assign w_fin    = r_dw == DWW'(T_COL - 1);
   assign w_ci_sig = (r_ci == CIW'(N_COLS - 1)) ? '0 : r_ci + CIW'(1);

   always_comb begin
      w_row = '0;
      for (int i = 0; i < N_FILAS; i++) if (r_fl[i]) w_row = RW'(i);
   end

   assign w_code = (MAPA_HEX == 1) ? CW'(HEX >> {w_row, r_ci, 2'b00})
                                   : CW'(int'(w_row) * N_COLS + int'(r_ci));

   always_comb begin
      w_est = r_est;
      w_ci  = r_ci;
      w_dw  = r_dw;
      w_k   = r_k;
      w_fl  = r_fl;
      w_acc = 1'b0;
      case (r_est)
         SCAN: begin
            w_dw = w_fin ? '0 : r_dw + DWW'(1);
            if (w_fin && w_uno) begin
               w_fl  = r_fs;
               w_k   = '0;
               w_est = DEB_P;
            end else if (w_fin) w_ci = w_ci_sig;
         end
         DEB_P:
            if (r_fs != r_fl) begin
               w_est = SCAN;
               w_ci  = w_ci_sig;
               w_dw  = '0;
            end else if (r_k == KW'(DEB_CNT - 1)) begin
               w_acc = 1'b1;
               w_est = PRES;
            end else w_k = r_k + KW'(1);
         PRES:
            if (r_fs == '0) begin
               w_k   = '0;
               w_est = DEB_R;
            end
         DEB_R:
            if (r_fs != '0) w_est = PRES;
            else if (r_k == KW'(DEB_CNT - 1)) begin
               w_est = SCAN;
               w_ci  = w_ci_sig;
               w_dw  = '0;
            end else w_k = r_k + KW'(1);
         default: w_est = SCAN;
      endcase
   end

   // a clear in the accept cycle wins over the push
   assign w_dig  = borrar ? '0 : w_acc ? (r_dig << CW) | DW'(w_code) : r_dig;
   assign w_desp = borrar ? '0 : !w_acc ? r_desp :
                   (r_desp == PW'(N_DIGITOS - 1)) ? '0 : r_desp + PW'(1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_fm    <= '0;
         r_fs    <= '0;
         r_est   <= SCAN;
         r_ci    <= '0;
         r_dw    <= '0;
         r_k     <= '0;
         r_fl    <= '0;
         r_tecla <= '0;
         r_val   <= 1'b0;
         r_dig   <= '0;
         r_desp  <= '0;
      end else begin
         r_fm    <= fila;
         r_fs    <= r_fm;
         r_est   <= w_est;
         r_ci    <= w_ci;
         r_dw    <= w_dw;
         r_k     <= w_k;
         r_fl    <= w_fl;
         r_tecla <= w_acc ? w_code : r_tecla;
         r_val   <= w_acc;
         r_dig   <= w_dig;
         r_desp  <= w_desp;
      end
endmodule
